// File: rtl/dmem_controller_pkg.sv
// Shared types for the data-memory controller.
// Size/error encodings, FSM states, default depth.
package dmem_controller_pkg;

   localparam int unsigned DMEM_SIZE = 1024;

   typedef enum logic [1:0] {
      MEM_BYTE    = 2'b00,
      MEM_HALF    = 2'b01,
      MEM_WORD    = 2'b10,
      MEM_ILLEGAL = 2'b11
   } mem_size_e;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_RANGE    = 2'b10,
      ERR_SIZE     = 2'b11
   } mem_err_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } dmem_state_e;

   // Byte lanes touched by an access of this size at this offset
   function automatic logic [3:0] byte_strobe(
      input mem_size_e  size,
      input logic [1:0] off
   );
      logic [3:0] s;
      s = 4'b0000;
      unique case (size)
         MEM_BYTE: s = 4'b0001 << off;
         MEM_HALF: s = off[1] ? 4'b1100 : 4'b0011;
         MEM_WORD: s = 4'b1111;
         default:  s = 4'b0000;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/dmem_controller_if.sv
// Request/response channels between the LSU and the
// data-memory controller.
interface dmem_controller_if;
   import dmem_controller_pkg::*;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   mem_size_e   req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   mem_err_e    rsp_err_code;

   modport master (
      output req_valid, req_write, req_size,
      output req_unsigned, req_addr, req_wdata,
      output rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata,
      input  rsp_err, rsp_err_code
   );

   modport slave (
      input  req_valid, req_write, req_size,
      input  req_unsigned, req_addr, req_wdata,
      input  rsp_ready,
      output req_ready, rsp_valid, rsp_rdata,
      output rsp_err, rsp_err_code
   );

endinterface

// File: rtl/dmem_controller_load_align.sv
// Extracts a byte/half/word lane from a RAM word and
// sign- or zero-extends it to 32 bits.
module dmem_load_align
   import dmem_controller_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  offset_i,
   input  mem_size_e   size_i,
   input  logic        uns_i,
   output logic [31:0] data_o
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Lane select then extension; word loads pass through
   always_comb begin
      lane_b = word_i[{offset_i, 3'b000} +: 8];
      lane_h = offset_i[1] ? word_i[31:16] : word_i[15:0];
      unique case (size_i)
         MEM_BYTE: data_o = {{24{~uns_i & lane_b[7]}}, lane_b};
         MEM_HALF: data_o = {{16{~uns_i & lane_h[15]}}, lane_h};
         default:  data_o = word_i;
      endcase
   end

endmodule

// File: rtl/dmem_controller.sv
// Data-memory controller: valid/ready requests, byte-strobe
// stores, latency-configurable registered responses.
module dmem_controller
   import dmem_controller_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS  = DMEM_SIZE,
   parameter int unsigned READ_LATENCY = 1,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
   input  logic             clk,
   input  logic             rst_n,
   dmem_controller_if.slave bus
);

   localparam int unsigned AW     = $clog2(DEPTH_WORDS);
   localparam logic [33:0] LIMIT  = 34'(DEPTH_WORDS) * 34'd4;
   localparam logic [2:0]  LAT_M1 = 3'(READ_LATENCY - 1);

   dmem_state_e state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   mem_err_e    err_q, err_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic          accept;
   logic [1:0]    off;
   logic [31:0]   rel;
   logic [AW-1:0] idx;
   mem_err_e      chk_err;
   logic [3:0]    strb;
   logic [31:0]   wlanes;
   logic [31:0]   rd_word;
   logic [31:0]   ld_data;

   assign bus.req_ready = (state_q == ST_IDLE) & rst_n;
   assign accept        = bus.req_valid & bus.req_ready;
   assign off           = bus.req_addr[1:0];
   assign rel           = bus.req_addr - BASE_ADDR;
   assign idx           = rel[AW+1:2];
   assign rd_word       = mem[idx];

   // Fault classification, highest priority first
   always_comb begin
      chk_err = ERR_NONE;
      if (bus.req_size == MEM_ILLEGAL)
         chk_err = ERR_SIZE;
      else if ((bus.req_size == MEM_HALF && off[0]) ||
               (bus.req_size == MEM_WORD && off != 2'b00))
         chk_err = ERR_MISALIGN;
      else if ({2'b00, rel} >= LIMIT)
         chk_err = ERR_RANGE;
   end

   // Strobes and store data replicated onto every lane
   always_comb begin
      strb = byte_strobe(bus.req_size, off);
      unique case (bus.req_size)
         MEM_BYTE: wlanes = {4{bus.req_wdata[7:0]}};
         MEM_HALF: wlanes = {2{bus.req_wdata[15:0]}};
         default:  wlanes = bus.req_wdata;
      endcase
   end

   dmem_load_align u_align (
      .word_i   (rd_word),
      .offset_i (off),
      .size_i   (bus.req_size),
      .uns_i    (bus.req_unsigned),
      .data_o   (ld_data)
   );

   // Fault-free stores commit their lanes on the accept edge
   always_ff @(posedge clk) begin
      if (accept && bus.req_write && chk_err == ERR_NONE) begin
         for (int i = 0; i < 4; i++) begin
            if (strb[i])
               mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
         end
      end
   end

   // Next-state, latency countdown and response capture
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               err_d   = chk_err;
               rdata_d = (!bus.req_write && chk_err == ERR_NONE)
                         ? ld_data : 32'h0;
               if (READ_LATENCY > 1) begin
                  state_d = ST_WAIT;
                  cnt_d   = LAT_M1;
               end else begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1)
               state_d = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rsp_ready)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
         rdata_q <= 32'h0;
         err_q   <= ERR_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign bus.rsp_valid    = (state_q == ST_RESP);
   assign bus.rsp_rdata    = rdata_q;
   assign bus.rsp_err      = (err_q != ERR_NONE);
   assign bus.rsp_err_code = err_q;

endmodule

// File: tb/tb_dmem_controller.sv
// Directed bench: three controllers at latencies 1, 3 and 4
// share stimulus; sel picks which one is driven and observed.
module tb_dmem_controller;
   import dmem_controller_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  sel = 2'd0;
   logic        v = 1'b0;
   logic        rr = 1'b0;
   logic        wr = 1'b0;
   logic [1:0]  sz = 2'b10;
   logic        uns = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_controller_if b1 ();
   dmem_controller_if b3 ();
   dmem_controller_if b4 ();

   assign b1.req_valid = v & (sel == 2'd0);
   assign b3.req_valid = v & (sel == 2'd1);
   assign b4.req_valid = v & (sel == 2'd2);
   assign b1.rsp_ready = rr & (sel == 2'd0);
   assign b3.rsp_ready = rr & (sel == 2'd1);
   assign b4.rsp_ready = rr & (sel == 2'd2);

   assign b1.req_write = wr;
   assign b3.req_write = wr;
   assign b4.req_write = wr;
   assign b1.req_size = mem_size_e'(sz);
   assign b3.req_size = mem_size_e'(sz);
   assign b4.req_size = mem_size_e'(sz);
   assign b1.req_unsigned = uns;
   assign b3.req_unsigned = uns;
   assign b4.req_unsigned = uns;
   assign b1.req_addr = addr;
   assign b3.req_addr = addr;
   assign b4.req_addr = addr;
   assign b1.req_wdata = wdata;
   assign b3.req_wdata = wdata;
   assign b4.req_wdata = wdata;

   dmem_controller #(.READ_LATENCY(1)) u_l1 (
      .clk(clk), .rst_n(rst_n), .bus(b1));
   dmem_controller #(.READ_LATENCY(3)) u_l3 (
      .clk(clk), .rst_n(rst_n), .bus(b3));
   dmem_controller #(.READ_LATENCY(4)) u_l4 (
      .clk(clk), .rst_n(rst_n), .bus(b4));

   logic        rq, rv, re;
   logic [31:0] rd;
   logic [1:0]  rc;

   always_comb begin
      unique case (sel)
         2'd0: begin
            rq = b1.req_ready; rv = b1.rsp_valid;
            rd = b1.rsp_rdata; re = b1.rsp_err;
            rc = b1.rsp_err_code;
         end
         2'd1: begin
            rq = b3.req_ready; rv = b3.rsp_valid;
            rd = b3.rsp_rdata; re = b3.rsp_err;
            rc = b3.rsp_err_code;
         end
         default: begin
            rq = b4.req_ready; rv = b4.rsp_valid;
            rd = b4.rsp_rdata; re = b4.rsp_err;
            rc = b4.rsp_err_code;
         end
      endcase
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h",
                  tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One full transaction; returns data, fault and latency
   task automatic xact(input logic w, input logic [1:0] s,
                       input logic u, input logic [31:0] a,
                       input logic [31:0] d,
                       output logic [31:0] o_rd,
                       output logic o_err,
                       output logic [1:0] o_code,
                       output int o_lat);
      int n;
      wr = w; sz = s; uns = u; addr = a; wdata = d; v = 1'b1;
      n = 0;
      while (!rq && n < 20) begin
         cyc();
         n++;
      end
      check("req_ready_wait", {31'b0, rq}, 32'd1);
      cyc();
      v = 1'b0;
      o_lat = 1;
      while (!rv && o_lat < 20) begin
         cyc();
         o_lat++;
      end
      o_rd = rd; o_err = re; o_code = rc;
      rr = 1'b1;
      cyc();
      rr = 1'b0;
   endtask

   task automatic run(input string tag, input logic w,
                      input logic [1:0] s, input logic u,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] e_rd,
                      input logic [1:0] e_code,
                      input int e_lat);
      logic [31:0] g_rd;
      logic        g_err;
      logic [1:0]  g_code;
      int          g_lat;
      xact(w, s, u, a, d, g_rd, g_err, g_code, g_lat);
      check({tag, "_rdata"}, g_rd, e_rd);
      check({tag, "_code"}, {30'b0, g_code}, {30'b0, e_code});
      check({tag, "_err"}, {31'b0, g_err},
            {31'b0, (e_code != 2'b00)});
      check({tag, "_lat"}, g_lat, e_lat);
   endtask

   logic [31:0] held;
   logic        seen;
   int          lat;

   initial begin
      // Reset values
      #2;
      for (int k = 0; k < 3; k++) begin
         sel = 2'(k);
         #1;
         check("rst_req_ready", {31'b0, rq}, 32'd0);
         check("rst_rsp_valid", {31'b0, rv}, 32'd0);
         check("rst_rdata", rd, 32'd0);
         check("rst_err", {29'b0, re, rc}, 32'd0);
      end
      sel = 2'd0;
      cyc();
      cyc();
      rst_n = 1'b1;
      #1;
      check("post_rst_ready", {31'b0, rq}, 32'd1);

      // Latency 1: word, byte, half, faults
      run("sw10", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 2'd0, 1);
      run("lw10", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 2'd0, 1);
      run("sw20", 1, 2'b10, 0, 32'h20, 32'h0, 32'h0, 2'd0, 1);
      run("sb23", 1, 2'b00, 0, 32'h23, 32'h80, 32'h0, 2'd0, 1);
      run("lb23", 0, 2'b00, 0, 32'h23, 32'h0, 32'hFFFFFF80, 2'd0, 1);
      run("lbu23", 0, 2'b00, 1, 32'h23, 32'h0, 32'h00000080, 2'd0, 1);
      run("lw20", 0, 2'b10, 0, 32'h20, 32'h0, 32'h80000000, 2'd0, 1);
      run("sw30", 1, 2'b10, 0, 32'h30, 32'h0, 32'h0, 2'd0, 1);
      run("sh32", 1, 2'b01, 0, 32'h32, 32'hA5F0, 32'h0, 2'd0, 1);
      run("lh32", 0, 2'b01, 0, 32'h32, 32'h0, 32'hFFFFA5F0, 2'd0, 1);
      run("lhu32", 0, 2'b01, 1, 32'h32, 32'h0, 32'h0000A5F0, 2'd0, 1);
      run("sh31", 1, 2'b01, 0, 32'h31, 32'h1234, 32'h0, 2'd1, 1);
      run("lw30", 0, 2'b10, 0, 32'h30, 32'h0, 32'hA5F00000, 2'd0, 1);
      run("lw1000", 0, 2'b10, 0, 32'h1000, 32'h0, 32'h0, 2'd2, 1);
      run("ill1001", 0, 2'b11, 0, 32'h1001, 32'h0, 32'h0, 2'd3, 1);
      run("swmis22", 1, 2'b10, 0, 32'h22, 32'hFFFFFFFF, 32'h0, 2'd1, 1);
      run("sboor", 1, 2'b00, 0, 32'h1000, 32'hFF, 32'h0, 2'd2, 1);
      run("sill20", 1, 2'b11, 0, 32'h20, 32'hFFFFFFFF, 32'h0, 2'd3, 1);
      run("lw20b", 0, 2'b10, 0, 32'h20, 32'h0, 32'h80000000, 2'd0, 1);
      run("lbmis", 0, 2'b00, 0, 32'h21, 32'h0, 32'h0, 2'd0, 1);
      run("swffc", 1, 2'b10, 0, 32'hFFC, 32'h11223344, 32'h0, 2'd0, 1);
      run("lbfff", 0, 2'b00, 1, 32'hFFF, 32'h0, 32'h00000011, 2'd0, 1);
      run("lhffe", 0, 2'b01, 0, 32'hFFE, 32'h0, 32'h00001122, 2'd0, 1);

      // Latency 3 with response backpressure
      sel = 2'd1;
      #1;
      run("l3_sw50", 1, 2'b10, 0, 32'h50, 32'hCAFEF00D, 32'h0, 2'd0, 3);
      wr = 0; sz = 2'b10; uns = 0; addr = 32'h50; v = 1'b1;
      cyc();
      lat = 1;
      while (!rv && lat < 20) begin
         cyc();
         lat++;
      end
      check("l3_lat", lat, 3);
      held = rd;
      check("l3_rdata", held, 32'hCAFEF00D);
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("l3_stall_valid", {31'b0, rv}, 32'd1);
         check("l3_stall_data", rd, held);
         check("l3_stall_ready", {31'b0, rq}, 32'd0);
      end
      rr = 1'b1;
      cyc();
      rr = 1'b0;
      check("l3_post_hs_ready", {31'b0, rq}, 32'd1);
      check("l3_post_hs_valid", {31'b0, rv}, 32'd0);
      cyc();
      v = 1'b0;
      check("l3_b2b_accepted", {31'b0, rq}, 32'd0);
      lat = 1;
      while (!rv && lat < 20) begin
         cyc();
         lat++;
      end
      check("l3_b2b_lat", lat, 3);
      check("l3_b2b_rdata", rd, 32'hCAFEF00D);
      rr = 1'b1;
      cyc();
      rr = 1'b0;

      // Latency 4: reset during WAIT aborts the response
      sel = 2'd2;
      #1;
      wr = 1; sz = 2'b10; uns = 0; addr = 32'h40;
      wdata = 32'h12345678; v = 1'b1;
      cyc();
      v = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b0;
      seen = 1'b0;
      #1;
      check("l4_rst_ready", {31'b0, rq}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         cyc();
         seen = seen | rv;
      end
      rst_n = 1'b1;
      #1;
      check("l4_rel_ready", {31'b0, rq}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         seen = seen | rv;
         cyc();
      end
      check("l4_no_rsp", {31'b0, seen}, 32'd0);
      run("l4_lw40", 0, 2'b10, 0, 32'h40, 32'h0, 32'h12345678, 2'd0, 4);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_controller.md
Name: dmem_controller

Overview:
Parametrised data-memory controller that succeeds the single-cycle combinational-read data memory.
- Adds a valid/ready request channel and a registered response channel with configurable read latency.
- Adds byte-strobe writes, and misaligned/out-of-range/illegal-size error reporting.
- Sits between the load/store unit of the multi-cycle/pipelined core and on-chip word-organised RAM. Holds at most one outstanding transaction.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two ≥ 4.
READ_LATENCY, 1, cycles from request acceptance to rsp_valid; legal range 1..4.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_write  in  1  1 = store, 0 = load
req_size  in  2  mem_size_e: 00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  transaction faulted
rsp_err_code  out  2  mem_err_e: 00 none, 01 misaligned, 10 out of range, 11 illegal size

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - req_ready=0 while rst_n low, then 1 from the first cycle after deassertion.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_err_code=00.
  - Latency counter = 0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - req_ready = (state==IDLE).
  - Accept = req_valid & req_ready at a rising edge. Request fields are sampled only on the accept edge.
  - IDLE → WAIT on accept when READ_LATENCY>1 (counter loaded with READ_LATENCY-1).
  - IDLE → RESP on accept when READ_LATENCY=1.
  - WAIT: counter decrements each cycle; WAIT → RESP when counter reaches 1.
  - RESP: rsp_valid=1, outputs held stable until rsp_valid & rsp_ready; then → IDLE.
  - The next request can be accepted in the cycle after the handshake, never in the same cycle.
- Timing: rsp_valid rises exactly READ_LATENCY cycles after the accept edge. Stores and faults follow the same latency.
- Error check, evaluated on the accept edge, in priority order:
  1. Illegal size (11).
  2. Misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
  3. Out of range: addr − BASE_ADDR ≥ DEPTH_WORDS*4, unsigned.
  A faulting transaction never modifies RAM and returns rsp_rdata=0.
- Stores:
  - Committed atomically on the accept edge using byte strobes derived from size and addr[1:0].
  - Byte: lane addr[1:0] receives wdata[7:0]. Half: lanes {addr[1],0} and {addr[1],1} receive wdata[15:0]. Word: all lanes.
  - Untouched lanes keep their value.
- Loads:
  - The RAM word is read on the accept edge and the lane is extracted by addr[1:0].
  - Result is sign- or zero-extended per req_unsigned; req_unsigned is ignored for word loads.
  - The result is pipelined to the output.
- Ordering: a load accepted after a store's response returns the stored data.
- Reset mid-transaction aborts it; no response is emitted. A store already accepted remains committed.
- rsp_ready held high in IDLE/WAIT has no effect.

Decomposition:
- riscv_pkg additions:
  - mem_size_e (MEM_BYTE, MEM_HALF, MEM_WORD, MEM_ILLEGAL).
  - mem_err_e (ERR_NONE, ERR_MISALIGN, ERR_RANGE, ERR_SIZE).
  - dmem_state_e.
  - DMEM_SIZE default, used as the DEPTH_WORDS default.
- One combinational sub-module, dmem_load_align: inputs word, offset, size, unsigned; output extended data. Shared with future caches.
- Strobe generation and the FSM stay in dmem_controller.

Test Plan:
1. Word store then load, READ_LATENCY=1: SW 0xDEADBEEF @0x10, then LW @0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 1 cycle after each accept.
2. Byte lanes and extension: SW 0x00000000 @0x20; SB 0x80 @0x23; LB @0x23 → 0xFFFFFF80; LBU @0x23 → 0x00000080; LW @0x20 → 0x80000000.
3. Halfword: SH 0xA5F0 @0x32, then LH @0x32 → 0xFFFFA5F0 and LHU @0x32 → 0x0000A5F0. SH @0x31 → rsp_err_code=01, and a subsequent LW @0x30 shows the word unchanged.
4. Error priority and range with DEPTH_WORDS=1024: LW @0x1000 → code 10. Size 11 @0x1001 → code 11 (illegal-size outranks misaligned and range). Faulting stores leave RAM unchanged.
5. Latency and backpressure, READ_LATENCY=3, rsp_ready held low 5 cycles: rsp_valid rises 3 cycles after accept; data stable while stalled; req_ready=0 until the cycle after the handshake; a back-to-back req_valid is accepted only then.
6. Reset mid-WAIT, READ_LATENCY=4: assert rst_n low 2 cycles after accepting an SW 0x12345678 @0x40 → rsp_valid never asserts, req_ready returns to 1 after release, and LW @0x40 → 0x12345678.
